// File: rtl/interrupt_controller.sv
// interrupt_controller
// Registered, parametrised interrupt controller for the bexkat1 CPU.
// Each source has a mask bit and an edge/level mode bit; edge sources latch
// into pending bits. The chosen exception code is held stable from the moment
// it is presented until the CPU acknowledges it.
module interrupt_controller #(
  parameter int NUM_IRQ   = 6,
  parameter int EXC_WIDTH = 4,
  parameter int VEC_BASE  = 1,
  parameter int IDLE_CODE = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_IRQ-1:0]   irq_i,
  input  logic                 enabled,
  input  logic                 ack_i,
  input  logic                 cfg_we_i,
  input  logic [1:0]           cfg_sel_i,
  input  logic [NUM_IRQ-1:0]   cfg_dat_i,
  output logic [NUM_IRQ-1:0]   cfg_dat_o,
  output logic [EXC_WIDTH-1:0] cpu_exception,
  output logic                 irq_active_o
);

  localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  // Register-select encodings for the configuration port.
  localparam logic [1:0] SEL_MASK = 2'd0;
  localparam logic [1:0] SEL_MODE = 2'd1;
  localparam logic [1:0] SEL_PEND = 2'd2;

  // Controller states: IDLE evaluates requests, REQ holds the presented code.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_REQ  = 1'b1;

  localparam logic [EXC_WIDTH-1:0] C_IDLE_CODE = EXC_WIDTH'(IDLE_CODE);
  localparam logic [EXC_WIDTH-1:0] C_VEC_BASE  = EXC_WIDTH'(VEC_BASE);

  // Highest set index wins: source NUM_IRQ-1 has the top priority.
  function automatic logic [IDX_W-1:0] f_top_index(input logic [NUM_IRQ-1:0] req);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (req[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  // One-hot vector selecting a single source.
  function automatic logic [NUM_IRQ-1:0] f_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_IRQ-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (IDX_W'(i) == idx) v[i] = 1'b1;
    end
    return v;
  endfunction

  logic [NUM_IRQ-1:0]   r_mask;
  logic [NUM_IRQ-1:0]   r_mode;
  logic [NUM_IRQ-1:0]   r_pend;
  logic [NUM_IRQ-1:0]   r_prev;
  logic [IDX_W-1:0]     r_cur_idx;
  logic [0:0]           r_state;
  logic [EXC_WIDTH-1:0] r_exc;

  logic                 w_mask_we;
  logic                 w_mode_we;
  logic                 w_pend_we;
  logic [NUM_IRQ-1:0]   w_mask_nxt;
  logic [NUM_IRQ-1:0]   w_mode_nxt;
  logic [NUM_IRQ-1:0]   w_edge_set;
  logic [NUM_IRQ-1:0]   w_ack_clr;
  logic [NUM_IRQ-1:0]   w_w1c_clr;
  logic [NUM_IRQ-1:0]   w_pend_nxt;
  logic [NUM_IRQ-1:0]   w_req;
  logic                 w_take;
  logic [IDX_W-1:0]     w_top_idx;
  logic [EXC_WIDTH-1:0] w_vec_code;

  // Configuration write decode and next values of the mask/mode registers.
  always_comb begin
    w_mask_we  = cfg_we_i && (cfg_sel_i == SEL_MASK);
    w_mode_we  = cfg_we_i && (cfg_sel_i == SEL_MODE);
    w_pend_we  = cfg_we_i && (cfg_sel_i == SEL_PEND);
    w_mask_nxt = w_mask_we ? cfg_dat_i : r_mask;
    w_mode_nxt = w_mode_we ? cfg_dat_i : r_mode;
  end

  // Pending-bit update: clears apply first so a coincident set wins; bits of
  // sources that are (or are becoming) level mode are forced to zero.
  always_comb begin
    w_edge_set = r_mode & irq_i & ~r_prev;
    w_ack_clr  = ((r_state == ST_REQ) && ack_i) ? f_onehot(r_cur_idx) : '0;
    w_w1c_clr  = w_pend_we ? cfg_dat_i : '0;
    w_pend_nxt = ((r_pend & ~(w_ack_clr | w_w1c_clr)) | w_edge_set) & w_mode_nxt;
  end

  // Effective requests and the code of the winning source.
  always_comb begin
    w_req      = r_mask & ((r_mode & r_pend) | (~r_mode & irq_i));
    w_take     = enabled && (|w_req);
    w_top_idx  = f_top_index(w_req);
    w_vec_code = C_VEC_BASE + EXC_WIDTH'(w_top_idx);
  end

  // Configuration, pending and edge-history registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mask <= '1;
      r_mode <= '0;
      r_pend <= '0;
      r_prev <= '0;
    end else begin
      r_mask <= w_mask_nxt;
      r_mode <= w_mode_nxt;
      r_pend <= w_pend_nxt;
      r_prev <= irq_i;
    end
  end

  // Request/acknowledge state machine; the presented code only changes on
  // entry to REQ or on the acknowledge that returns to IDLE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_cur_idx <= '0;
      r_exc     <= C_IDLE_CODE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_take) begin
            r_state   <= ST_REQ;
            r_cur_idx <= w_top_idx;
            r_exc     <= w_vec_code;
          end else begin
            r_exc <= C_IDLE_CODE;
          end
        end
        ST_REQ: begin
          if (ack_i) begin
            r_state <= ST_IDLE;
            r_exc   <= C_IDLE_CODE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_exc   <= C_IDLE_CODE;
        end
      endcase
    end
  end

  // Combinational register readback; the reserved select reads as zero.
  always_comb begin
    cfg_dat_o = '0;
    case (cfg_sel_i)
      SEL_MASK: cfg_dat_o = r_mask;
      SEL_MODE: cfg_dat_o = r_mode;
      SEL_PEND: cfg_dat_o = r_pend;
      default:  cfg_dat_o = '0;
    endcase
  end

  assign cpu_exception = r_exc;
  assign irq_active_o  = (r_state == ST_REQ);

endmodule

// File: tb/tb_interrupt_controller.sv
// Testbench for interrupt_controller: directed scenarios followed by a
// randomized phase, all compared against a behavioural reference model.
module tb_interrupt_controller;

  localparam int N  = 6;
  localparam int EW = 4;
  localparam int VB = 1;
  localparam int IC = 0;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  irq;
  logic          en;
  logic          ack;
  logic          cfg_we;
  logic [1:0]    cfg_sel;
  logic [N-1:0]  cfg_dat_in;
  logic [N-1:0]  cfg_dat_out;
  logic [EW-1:0] exc;
  logic          active;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [N-1:0] m_mask, m_mode, m_pend, m_prev;
  bit           m_busy;
  int           m_idx;
  int           m_code;

  interrupt_controller #(
    .NUM_IRQ(N), .EXC_WIDTH(EW), .VEC_BASE(VB), .IDLE_CODE(IC)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .irq_i(irq),
    .enabled(en),
    .ack_i(ack),
    .cfg_we_i(cfg_we),
    .cfg_sel_i(cfg_sel),
    .cfg_dat_i(cfg_dat_in),
    .cfg_dat_o(cfg_dat_out),
    .cpu_exception(exc),
    .irq_active_o(active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: advance one clock edge using the inputs currently driven.
  task automatic model_next();
    int best;
    logic [N-1:0] np, nmask, nmode;
    if (rst) begin
      m_mask = '1; m_mode = '0; m_pend = '0; m_prev = '0;
      m_busy = 0; m_idx = 0; m_code = IC;
      return;
    end
    best = -1;
    for (int i = 0; i < N; i++) begin
      bit r;
      r = m_mask[i] && (m_mode[i] ? m_pend[i] : irq[i]);
      if (r) best = i;
    end
    nmask = (cfg_we && cfg_sel == 2'd0) ? cfg_dat_in : m_mask;
    nmode = (cfg_we && cfg_sel == 2'd1) ? cfg_dat_in : m_mode;
    for (int i = 0; i < N; i++) begin
      bit p;
      p = m_pend[i];
      if (m_busy && ack && m_idx == i) p = 0;
      if (cfg_we && cfg_sel == 2'd2 && cfg_dat_in[i]) p = 0;
      if (m_mode[i] && irq[i] && !m_prev[i]) p = 1;
      if (!nmode[i]) p = 0;
      np[i] = p;
    end
    if (!m_busy) begin
      if (en && best >= 0) begin
        m_busy = 1; m_idx = best; m_code = VB + best;
      end else begin
        m_code = IC;
      end
    end else if (ack) begin
      m_busy = 0; m_code = IC;
    end
    m_pend = np; m_mask = nmask; m_mode = nmode; m_prev = irq;
  endtask

  function automatic logic [N-1:0] model_rd(input logic [1:0] sel);
    case (sel)
      2'd0:    return m_mask;
      2'd1:    return m_mode;
      2'd2:    return m_pend;
      default: return '0;
    endcase
  endfunction

  // One clock: update model, wait for the edge, compare just after it.
  task automatic step();
    model_next();
    @(posedge clk);
    #1;
    chk("model_code", 32'(exc), 32'(m_code));
    chk("model_active", 32'(active), 32'(m_busy));
    chk("model_rd", 32'(cfg_dat_out), 32'(model_rd(cfg_sel)));
  endtask

  task automatic wr(input logic [1:0] sel, input logic [N-1:0] dat);
    cfg_we = 1'b1; cfg_sel = sel; cfg_dat_in = dat;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [1:0] sel, input logic [N-1:0] exp);
    cfg_sel = sel;
    #1;
    chk(tag, 32'(cfg_dat_out), 32'(exp));
  endtask

  task automatic code_is(input string tag, input int exp_code, input bit exp_act);
    chk({tag, "_code"}, 32'(exc), 32'(exp_code));
    chk({tag, "_act"}, 32'(active), 32'(exp_act));
  endtask

  initial begin
    rst = 1'b1; irq = '0; en = 1'b1; ack = 1'b0;
    cfg_we = 1'b0; cfg_sel = 2'd0; cfg_dat_in = '0;

    // Reset state
    step();
    step();
    rst = 1'b0;
    code_is("reset", 0, 0);
    rd("reset_mask", 2'd0, 6'h3F);
    rd("reset_mode", 2'd1, 6'h00);
    rd("reset_pend", 2'd2, 6'h00);
    rd("reset_rsvd", 2'd3, 6'h00);

    // Fixed priority among level sources 0 and 2
    irq = 6'b000101;
    step(); code_is("prio", 3, 1);
    step(); code_is("prio_hold", 3, 1);
    ack = 1'b1; irq = '0;
    step(); code_is("prio_ack", 0, 0);
    ack = 1'b0;
    step(); code_is("prio_idle", 0, 0);

    // Level source held through priority changes until ack
    irq = 6'b100000;
    step(); code_is("lvl", 6, 1);
    irq = 6'b010000;
    step(); code_is("lvl_hold", 6, 1);
    ack = 1'b1;
    step(); code_is("lvl_ack", 0, 0);
    ack = 1'b0;
    step(); code_is("lvl_next", 5, 1);
    ack = 1'b1; irq = '0;
    step(); code_is("lvl_ack2", 0, 0);
    ack = 1'b0;

    // Edge source 0
    wr(2'd1, 6'b000001);
    irq = 6'b000001;
    step(); code_is("edge_lat1", 0, 0);
    irq = '0;
    rd("edge_pend", 2'd2, 6'b000001);
    step(); code_is("edge_code", 1, 1);
    ack = 1'b1; irq = 6'b000001;
    step(); code_is("edge_ack", 0, 0);
    rd("edge_setwins", 2'd2, 6'b000001);
    ack = 1'b0; irq = '0;
    step(); code_is("edge_again", 1, 1);
    ack = 1'b1;
    step(); code_is("edge_ack2", 0, 0);
    ack = 1'b0;
    rd("edge_clr", 2'd2, 6'b000000);

    // Masked edge source still latches
    wr(2'd0, 6'b111110);
    irq = 6'b000001;
    step();
    irq = '0;
    step(); code_is("mask_none", 0, 0);
    rd("mask_pend", 2'd2, 6'b000001);
    wr(2'd0, 6'b111111);
    code_is("mask_old", 0, 0);
    step(); code_is("mask_req", 1, 1);
    ack = 1'b1;
    step();
    ack = 1'b0;

    // Write-1-to-clear of a latched bit
    wr(2'd0, 6'b111110);
    irq = 6'b000001;
    step();
    irq = '0;
    rd("w1c_before", 2'd2, 6'b000001);
    wr(2'd2, 6'b000001);
    rd("w1c_after", 2'd2, 6'b000000);
    wr(2'd0, 6'b111111);
    step(); code_is("w1c_idle", 0, 0);

    // Switching to level clears stale pending bits
    irq = 6'b000001;
    wr(2'd0, 6'b111110);
    irq = '0;
    step();
    wr(2'd1, 6'b000000);
    rd("mode_clr", 2'd2, 6'b000000);
    wr(2'd0, 6'b111111);

    // Global enable
    en = 1'b0; irq = 6'b111111;
    step(); code_is("en_off", 0, 0);
    step(); code_is("en_off2", 0, 0);
    en = 1'b1;
    step(); code_is("en_on", 6, 1);
    en = 1'b0;
    step(); code_is("en_drop", 6, 1);
    irq = '0;
    step(); code_is("en_drop2", 6, 1);
    ack = 1'b1;
    step(); code_is("en_ack", 0, 0);
    ack = 1'b0; en = 1'b1;
    step();

    // Reset in the middle of REQ
    wr(2'd1, 6'b000011);
    irq = 6'b001000;
    step(); code_is("rst_pre", 4, 1);
    rst = 1'b1;
    step(); code_is("rst_mid", 0, 0);
    rst = 1'b0; irq = '0;
    rd("rst_mask", 2'd0, 6'h3F);
    rd("rst_mode", 2'd1, 6'h00);
    rd("rst_pend", 2'd2, 6'h00);
    step();

    // Randomized phase against the model
    for (int c = 0; c < 3000; c++) begin
      rst        = ($urandom_range(0, 199) == 0);
      irq        = N'($urandom);
      en         = ($urandom_range(0, 7) != 0);
      ack        = ($urandom_range(0, 3) == 0);
      cfg_we     = ($urandom_range(0, 9) == 0);
      cfg_sel    = 2'($urandom);
      cfg_dat_in = N'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
